// File: rtl/uart_atlantix_pkg.sv
// uart_atlantix_pkg: shared FSM encoding and framing constants for the Atlantix UART pair
package uart_atlantix_pkg;
   typedef enum logic [5:0] {
      IDLE   = 6'b000001,
      START  = 6'b000010,
      DATA   = 6'b000100,
      PARITY = 6'b001000,
      STOP   = 6'b010000,
      DONE   = 6'b100000
   } tx_state_t;
   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_START_LVL = 1'b0;
   localparam logic UART_STOP_LVL  = 1'b1;
endpackage

// File: rtl/uart_baud_tick_atlantix.sv
// uart_baud_tick_atlantix: bit-period counter producing a one-cycle tick every MCLKS_PER_BIT cycles
//   MCLK      in  system clock
//   HRST_N    in  synchronous active-low reset
//   i_CLEAR   in  restart the bit period (frame accept)
//   i_ENABLE  in  count while a frame is on the line
//   o_TICK    out one-cycle strobe at terminal count MCLKS_PER_BIT-1
module uart_baud_tick_atlantix #(
   parameter int MCLKS_PER_BIT = 434
) (
   input  logic MCLK,
   input  logic HRST_N,
   input  logic i_CLEAR,
   input  logic i_ENABLE,
   output logic o_TICK
);
   localparam int W = (MCLKS_PER_BIT > 1) ? $clog2(MCLKS_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(MCLKS_PER_BIT - 1);
   logic [W-1:0] cnt;
   assign o_TICK = i_ENABLE & (cnt == LAST);
   always_ff @(posedge MCLK) begin
      if (!HRST_N || i_CLEAR || o_TICK) cnt <= '0;
      else if (i_ENABLE) cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/uart_tx_atlantix.sv
// uart_tx_atlantix: Atlantix UART transmitter, 8 data bits LSB-first, 1 stop bit, optional even parity
//   MCLK     in  system clock (100 MHz)
//   HRST_N   in  synchronous active-low reset
//   i_DATA   in  byte to send, sampled on accept
//   i_VALID  in  send request
//   o_READY  out idle and out of reset; accept = i_VALID & o_READY
//   o_TXD    out registered serial line, idles high
//   o_BUSY   out frame on the line (start..stop)
//   o_DONE   out one-cycle pulse after the stop bit
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_atlantix
   import uart_atlantix_pkg::*;
#(
   parameter int MCLKS_PER_BIT = 434
) (
   input  logic       MCLK,
   input  logic       HRST_N,
   input  logic [7:0] i_DATA,
   input  logic       i_VALID,
   output logic       o_READY,
   output logic       o_TXD,
   output logic       o_BUSY,
   output logic       o_DONE
);
   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
   tx_state_t state, state_nx;
   logic [UART_DATA_BITS-1:0] shreg, shreg_nx;
   logic [2:0] bitcnt, bitcnt_nx;
   logic txd, txd_nx, accept, tick;
`ifdef UART_TX_PARITY_EN
   logic par;
`endif
   assign o_READY = (state == IDLE) & HRST_N;
   assign accept  = i_VALID & o_READY;
   assign o_BUSY  = (state == START) | (state == DATA) | (state == PARITY) | (state == STOP);
   assign o_DONE  = state == DONE;
   assign o_TXD   = txd;
   uart_baud_tick_atlantix #(.MCLKS_PER_BIT(MCLKS_PER_BIT)) u_tick (
      .MCLK    (MCLK),
      .HRST_N  (HRST_N),
      .i_CLEAR (accept),
      .i_ENABLE(o_BUSY),
      .o_TICK  (tick)
   );
   always_comb begin
      state_nx  = state;
      shreg_nx  = shreg;
      bitcnt_nx = bitcnt;
      case (state)
         IDLE: if (accept) begin
            state_nx  = START;
            shreg_nx  = i_DATA;
            bitcnt_nx = '0;
         end
         START: if (tick) state_nx = DATA;
         DATA: if (tick) begin
            shreg_nx  = shreg >> 1;
            bitcnt_nx = bitcnt + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bitcnt == LAST_BIT) state_nx = PARITY;
`else
            if (bitcnt == LAST_BIT) state_nx = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (tick) state_nx = STOP;
`endif
         STOP: if (tick) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
      // line level is registered from the next state so it changes together with the state
      txd_nx = (state_nx == START) ? UART_START_LVL :
               (state_nx == DATA)  ? shreg_nx[0]    : UART_STOP_LVL;
`ifdef UART_TX_PARITY_EN
      if (state_nx == PARITY) txd_nx = par;
`endif
   end
   always_ff @(posedge MCLK) begin
      if (!HRST_N) begin
         state  <= IDLE;
         shreg  <= '0;
         bitcnt <= '0;
         txd    <= UART_STOP_LVL;
      end else begin
         state  <= state_nx;
         shreg  <= shreg_nx;
         bitcnt <= bitcnt_nx;
         txd    <= txd_nx;
      end
   end
`ifdef UART_TX_PARITY_EN
   always_ff @(posedge MCLK) begin
      if (!HRST_N) par <= 1'b0;
      else if (accept) par <= ^i_DATA;
   end
`endif
endmodule
